// File: rtl/ca_row_engine.sv
// ca_row_engine
//   Elementary (1-D, radius-1) cellular automaton renderer for the VGA
//   pixel-plot stage. On start it paints generation 0 on screen row 0, then
//   each following generation on the next row, one cell per clock. The
//   cell ring is toroidal: cell 0 and cell CELLS-1 are neighbours.
//
// Parameters
//   CELLS     cells per generation / screen width in pixels (<= 256)
//   ROWS      generations per frame / screen height in pixels (<= 128)
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   load_seed  in   pulse: latch seed (ignored while busy)
//   seed       in   9-bit initial pattern, centred in the ring
//   load_rule  in   pulse: latch rule (ignored while busy)
//   rule       in   8-bit Wolfram rule number
//   start      in   pulse: begin a frame (ignored while busy)
//   x, y       out  pixel coordinate
//   colour     out  3'b111 live, 3'b000 dead
//   plot       out  framebuffer write strobe
//   busy       out  high while drawing
//   done       out  high after a completed frame until the next start/reset
module ca_row_engine #(
   parameter int unsigned CELLS = 160,
   parameter int unsigned ROWS  = 120
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       load_seed,
   input  logic [8:0] seed,
   input  logic       load_rule,
   input  logic [7:0] rule,
   input  logic       start,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      NEXT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [7:0]  X_LAST    = 8'(CELLS - 1);
   localparam logic [6:0]  Y_LAST    = 7'(ROWS - 1);
   localparam int unsigned SEED_BASE = CELLS / 2 - 4;

   state_t           state;
   state_t           state_nx;

   logic [8:0]       seed_r;
   logic [7:0]       rule_r;
   logic [CELLS-1:0] row;
   logic [7:0]       xc;
   logic [6:0]       yc;

   logic             accept;
   logic [8:0]       seed_use;
   logic [CELLS-1:0] row_seed;
   logic [CELLS-1:0] lft;
   logic [CELLS-1:0] rgt;
   logic [CELLS-1:0] row_next;

   // Loads and start are only honoured when not drawing.
   assign accept = (state == IDLE) || (state == DONE);

   // A seed loaded in the same cycle as start is used by that frame.
   assign seed_use = load_seed ? seed : seed_r;
   assign row_seed = {{(CELLS - 9){1'b0}}, seed_use} << SEED_BASE;

   // lft[i] = row[i-1], rgt[i] = row[i+1], both wrapping around the ring.
   assign lft = {row[CELLS-2:0], row[CELLS-1]};
   assign rgt = {row[0], row[CELLS-1:1]};

   always_comb begin
      row_next = '0;
      for (int unsigned i = 0; i < CELLS; i++) begin
         row_next[i] = rule_r[{lft[i], row[i], rgt[i]}];
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = DRAW;
            end
         end
         DRAW: begin
            if (xc == X_LAST) begin
               state_nx = (yc == Y_LAST) ? DONE : NEXT;
            end
         end
         NEXT: begin
            state_nx = DRAW;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         seed_r <= 9'b000010000;
         rule_r <= 8'd30;
         row    <= '0;
         xc     <= '0;
         yc     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_seed) begin
                  seed_r <= seed;
               end
               if (load_rule) begin
                  rule_r <= rule;
               end
               if (start) begin
                  row <= row_seed;
                  xc  <= '0;
                  yc  <= '0;
               end
            end
            DRAW: begin
               xc <= xc + 8'd1;
            end
            NEXT: begin
               row <= row_next;
               yc  <= yc + 7'd1;
               xc  <= '0;
            end
            default: begin
               xc <= '0;
            end
         endcase
      end
   end

   // Outputs are a registered decode of the current state, so every
   // output (plot, busy, done) trails the state register by one clock.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot   <= (state == DRAW);
         busy   <= (state == DRAW) || (state == NEXT);
         done   <= (state == DONE);
         colour <= 3'b000;
         if (state == DRAW) begin
            x      <= xc;
            y      <= yc;
            colour <= row[xc] ? 3'b111 : 3'b000;
         end
      end
   end

endmodule

// File: tb/tb_ca_row_engine.sv
module tb_ca_row_engine;

   logic       clk;
   logic       reset;
   logic       load_seed;
   logic [8:0] seed;
   logic       load_rule;
   logic [7:0] rule;
   logic       start;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   int checks = 0;
   int fails  = 0;

   // Frame capture written only by the monitor; seq is written only by
   // the stimulus process so each frame's pixels can be told apart.
   logic [2:0] fb    [0:127][0:255];
   int         stamp [0:127][0:255];
   int         seq = 0;
   int         plot_total  = 0;
   int         runs_total  = 0;
   int         run_bad     = 0;
   int         gap_cycles  = 0;
   int         run_len     = 0;

   ca_row_engine #(.CELLS(160), .ROWS(120)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .load_seed(load_seed),
      .seed     (seed),
      .load_rule(load_rule),
      .rule     (rule),
      .start    (start),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (plot) begin
         fb[y][x]    = colour;
         stamp[y][x] = seq;
         plot_total++;
         run_len++;
      end else begin
         if (run_len != 0) begin
            runs_total++;
            if (run_len != 160) run_bad++;
         end
         run_len = 0;
         if (busy) gap_cycles++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Number of cells in captured row r (current frame) that differ from
   // the live-cell mask; cells not plotted this frame count as wrong.
   function automatic int row_errors(input int r, input logic [159:0] mask);
      int e = 0;
      logic [2:0] got;
      logic [2:0] want;
      for (int xx = 0; xx < 160; xx++) begin
         got  = (stamp[r][xx] == seq) ? fb[r][xx] : 3'b010;
         want = mask[xx] ? 3'b111 : 3'b000;
         if (got !== want) e++;
      end
      return e;
   endfunction

   task automatic test_reset();
      logic [159:0] m;
      int e;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({x, y, colour, plot, busy, done} !== 21'd0) begin
         fails++;
         $display("FAIL reset_outputs: got x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b, want all 0",
                  x, y, colour, plot, busy, done);
      end
      seq++;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({plot, busy} !== 2'b00) begin
         fails++;
         $display("FAIL start_latency0: plot=%b busy=%b, want 0 0", plot, busy);
      end
      tick();
      checks++;
      if ({plot, busy, x, y} !== {1'b1, 1'b1, 8'd0, 7'd0}) begin
         fails++;
         $display("FAIL first_plot: plot=%b busy=%b x=%0d y=%0d, want 1 1 0 0", plot, busy, x, y);
      end
      for (int i = 0; i < 2 * 161 + 2; i++) tick();
      m = '0; m[80] = 1'b1;
      e = row_errors(0, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL default_row0: %0d wrong cells, want only x=80 live", e);
      end
      m = '0; m[79] = 1'b1; m[80] = 1'b1; m[81] = 1'b1;
      e = row_errors(1, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL default_row1_rule30: %0d wrong cells, want x=79,80,81 live", e);
      end
   endtask

   task automatic test_rule90();
      logic [159:0] m;
      int e;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rule = 8'd90;
      load_rule = 1'b1;
      tick();
      load_rule = 1'b0;
      rule = 8'd0;
      seq++;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 3 * 161 + 2; n++) begin
         tick();
         if (n == 160) begin
            checks++;
            if ({plot, x, y} !== {1'b1, 8'd159, 7'd0}) begin
               fails++;
               $display("FAIL row0_last: plot=%b x=%0d y=%0d, want 1 159 0", plot, x, y);
            end
         end
         if (n == 161) begin
            checks++;
            if ({plot, busy} !== 2'b01) begin
               fails++;
               $display("FAIL next_gap: plot=%b busy=%b, want 0 1", plot, busy);
            end
         end
         if (n == 162) begin
            checks++;
            if ({plot, x, y} !== {1'b1, 8'd0, 7'd1}) begin
               fails++;
               $display("FAIL row1_first: plot=%b x=%0d y=%0d, want 1 0 1", plot, x, y);
            end
         end
      end
      m = '0; m[80] = 1'b1;
      e = row_errors(0, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL r90_row0: %0d wrong cells, want only x=80 live", e);
      end
      m = '0; m[79] = 1'b1; m[81] = 1'b1;
      e = row_errors(1, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL r90_row1: %0d wrong cells, want x=79,81 live", e);
      end
      m = '0; m[78] = 1'b1; m[82] = 1'b1;
      e = row_errors(2, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL r90_row2: %0d wrong cells, want x=78,82 live", e);
      end
   endtask

   // Rule 170 shifts the pattern one cell left per generation. Seed, rule
   // and start arrive together; a rule-0 load and a start are injected
   // mid-frame and must have no effect.
   task automatic test_wrap_frame();
      logic [159:0] m;
      int e, n, p0, r0, rb0, g0, bad_rows;
      logic got_done;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      seq++;
      seed = 9'b000000001; load_seed = 1'b1;
      rule = 8'd170;       load_rule = 1'b1;
      start = 1'b1;
      tick();
      load_seed = 1'b0; load_rule = 1'b0; start = 1'b0;
      seed = 9'h1ff;
      p0 = plot_total; r0 = runs_total; rb0 = run_bad; g0 = gap_cycles;
      n = 0;
      got_done = 1'b0;
      while (n < 20000 && !got_done) begin
         if (n == 5000) begin
            rule = 8'd0; load_rule = 1'b1; load_seed = 1'b1; start = 1'b1;
         end else begin
            load_rule = 1'b0; load_seed = 1'b0; start = 1'b0;
         end
         tick();
         n++;
         if (n == 19319) begin
            checks++;
            if ({plot, x, y, done} !== {1'b1, 8'd159, 7'd119, 1'b0}) begin
               fails++;
               $display("FAIL last_plot: plot=%b x=%0d y=%0d done=%b, want 1 159 119 0",
                        plot, x, y, done);
            end
         end
         if (done) got_done = 1'b1;
      end
      checks++;
      if (n != 19320) begin
         fails++;
         $display("FAIL done_latency: done after %0d cycles, want 19320", n);
      end
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL busy_at_done: busy=%b, want 0", busy);
      end
      tick();
      tick();
      checks++;
      if (plot_total - p0 != 19200) begin
         fails++;
         $display("FAIL plot_count: %0d plots, want 19200", plot_total - p0);
      end
      checks++;
      if (runs_total - r0 != 120 || run_bad - rb0 != 0) begin
         fails++;
         $display("FAIL plot_runs: %0d runs, %0d not 160 long, want 120 and 0",
                  runs_total - r0, run_bad - rb0);
      end
      checks++;
      if (gap_cycles - g0 != 119) begin
         fails++;
         $display("FAIL next_gaps: %0d gap cycles, want 119", gap_cycles - g0);
      end
      checks++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL done_hold: done=%b, want 1", done);
      end
      bad_rows = 0;
      for (int r = 0; r < 120; r++) begin
         m = '0;
         m[(236 - r) % 160] = 1'b1;
         e = row_errors(r, m);
         checks++;
         if (e != 0) begin
            fails++;
            bad_rows++;
            if (bad_rows <= 5)
               $display("FAIL wrap_row%0d: %0d wrong cells, want only x=%0d live", r, e, (236 - r) % 160);
         end
      end
      checks++;
      if (!(stamp[77][159] == seq && fb[77][159] === 3'b111)) begin
         fails++;
         $display("FAIL wrap_y77_x159: colour=%0d, want 7", fb[77][159]);
      end
      checks++;
      if (!(stamp[78][158] == seq && fb[78][158] === 3'b111)) begin
         fails++;
         $display("FAIL wrap_y78_x158: colour=%0d, want 7", fb[78][158]);
      end
   endtask

   task automatic test_restart_old_rule();
      logic [159:0] m;
      int e;
      seq++;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({busy, done} !== 2'b10) begin
         fails++;
         $display("FAIL restart_flags: busy=%b done=%b, want 1 0", busy, done);
      end
      for (int i = 0; i < 2 * 161 + 2; i++) tick();
      m = '0; m[76] = 1'b1;
      e = row_errors(0, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL restart_row0: %0d wrong cells, want only x=76 live", e);
      end
      m = '0; m[75] = 1'b1;
      e = row_errors(1, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL restart_row1: %0d wrong cells, want only x=75 live", e);
      end
   endtask

   task automatic test_reset_mid();
      logic [159:0] m;
      int e, n;
      n = 0;
      while (!(plot === 1'b1 && y === 7'd50) && n < 20000) begin
         tick();
         n++;
      end
      checks++;
      if (!(plot === 1'b1 && y === 7'd50)) begin
         fails++;
         $display("FAIL reach_y50: plot=%b y=%0d, want 1 50", plot, y);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({x, y, colour, plot, busy, done} !== 21'd0) begin
         fails++;
         $display("FAIL mid_reset: x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b, want all 0",
                  x, y, colour, plot, busy, done);
      end
      tick();
      checks++;
      if ({plot, busy} !== 2'b00) begin
         fails++;
         $display("FAIL mid_reset_idle: plot=%b busy=%b, want 0 0", plot, busy);
      end
      seq++;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({plot, x, y} !== {1'b1, 8'd0, 7'd0}) begin
         fails++;
         $display("FAIL mid_restart_first: plot=%b x=%0d y=%0d, want 1 0 0", plot, x, y);
      end
      for (int i = 0; i < 2 * 161 + 2; i++) tick();
      m = '0; m[80] = 1'b1;
      e = row_errors(0, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL mid_restart_row0: %0d wrong cells, want only x=80 live", e);
      end
      m = '0; m[79] = 1'b1; m[80] = 1'b1; m[81] = 1'b1;
      e = row_errors(1, m);
      checks++;
      if (e != 0) begin
         fails++;
         $display("FAIL mid_restart_row1: %0d wrong cells, want x=79,80,81 live", e);
      end
   endtask

   initial begin
      reset = 1'b1;
      load_seed = 1'b0;
      seed = 9'd0;
      load_rule = 1'b0;
      rule = 8'd0;
      start = 1'b0;
      test_reset();
      test_rule90();
      test_wrap_frame();
      test_restart_old_rule();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
